// File: rtl/prog_loader.sv
// Program loader: assembles 16-bit halfwords into 32-bit instruction words, holds the core in reset until loaded.
// Optional checksum stage enabled by defining LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [15:0]   s_data,
  input  logic          s_last,
  input  logic [AW-1:0] fetch_addr,
  output logic [31:0]   fetch_data,
  output logic          core_rst,
  output logic          done,
  output logic          err,
  output logic [AW:0]   word_count
);

  localparam logic [31:0] HALT_OP = 32'hD800_0000;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_HI = 3'd1;
  localparam logic [2:0] S_LOAD_LO = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERROR   = 3'd5;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK     = 3'd6;
`endif

  logic [2:0]  state_q, state_d;
  logic [15:0] hi_q, hi_d;
  logic [15:0] lo_q, lo_d;
  logic        last_q, last_d;
  logic [AW:0] wcount_q, wcount_d;
  logic        s_ready_q, core_rst_q, done_q, err_q;
  logic        mem_we;
  logic        xfer;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] xsum_q, xsum_d;
`endif

  logic [31:0] mem [DEPTH];

  assign xfer       = s_valid && s_ready_q;
  assign s_ready    = s_ready_q;
  assign core_rst   = core_rst_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = wcount_q;

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    last_d   = last_q;
    wcount_d = wcount_q;
    mem_we   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    xsum_d   = xsum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          wcount_d = '0;
          state_d  = S_LOAD_HI;
`ifdef LOADER_CHECKSUM_EN
          xsum_d   = '0;
`endif
        end
      end
      S_LOAD_HI: begin
        if (xfer) begin
          hi_d    = s_data;
          state_d = s_last ? S_ERROR : S_LOAD_LO;
`ifdef LOADER_CHECKSUM_EN
          xsum_d  = xsum_q ^ s_data;
`endif
        end
      end
      S_LOAD_LO: begin
        if (xfer) begin
          lo_d    = s_data;
          last_d  = s_last;
          state_d = S_WRITE;
`ifdef LOADER_CHECKSUM_EN
          xsum_d  = xsum_q ^ s_data;
`endif
        end
      end
      S_WRITE: begin
        mem_we   = 1'b1;
        wcount_d = wcount_q + (AW+1)'(1);
        if (last_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else if (wcount_d == (AW+1)'(DEPTH)) begin
          state_d = S_ERROR;
        end else begin
          state_d = S_LOAD_HI;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) begin
          state_d = (s_data == xsum_q) ? S_DONE : S_ERROR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered status outputs, decoded from the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      last_q     <= 1'b0;
      wcount_q   <= '0;
      s_ready_q  <= 1'b0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xsum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      last_q     <= last_d;
      wcount_q   <= wcount_d;
`ifdef LOADER_CHECKSUM_EN
      s_ready_q  <= (state_d == S_LOAD_HI) || (state_d == S_LOAD_LO) || (state_d == S_CHK);
      xsum_q     <= xsum_d;
`else
      s_ready_q  <= (state_d == S_LOAD_HI) || (state_d == S_LOAD_LO);
`endif
      core_rst_q <= (state_d != S_DONE);
      done_q     <= (state_d == S_DONE);
      err_q      <= (state_d == S_ERROR);
    end
  end

  // Instruction memory is not reset; visibility is gated by done and word_count
  always_ff @(posedge clock) begin
    if (!reset && mem_we) begin
      mem[wcount_q[AW-1:0]] <= {hi_q, lo_q};
    end
  end

  always_comb begin
    fetch_data = HALT_OP;
    if (done_q && ({1'b0, fetch_addr} < wcount_q)) begin
      fetch_data = mem[fetch_addr];
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed, table-driven bench for prog_loader; checksum cases follow LOADER_CHECKSUM_EN.
module tb_prog_loader;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam logic [31:0] HALT  = 32'hD800_0000;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          s_valid;
  logic          s_ready;
  logic [15:0]   s_data;
  logic          s_last;
  logic [AW-1:0] fetch_addr;
  logic [31:0]   fetch_data;
  logic          core_rst;
  logic          done;
  logic          err;
  logic [AW:0]   word_count;

  int errors = 0;
  int checks = 0;
  int load_id = 0;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] ck_acc;
  logic        ck_corrupt = 1'b0;
`endif

  prog_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .core_rst   (core_rst),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    int nwords;
    bit odd;
    bit exp_done;
    bit exp_err;
    int exp_cnt;
  } load_vec_t;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int i, input int k);
    logic [15:0] hi;
    logic [15:0] lo;
    hi = 16'(16'h1000 + 16'(k * 16) + 16'(i));
    lo = 16'(16'h2000 + 16'(i * 3) + 16'(k));
    return {hi, lo};
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    ck_acc = 16'h0;
`endif
  endtask

  // Offer one halfword until accepted, bounded
  task automatic send_hw(input logic [15:0] d, input logic l);
    bit got;
    got = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (int c = 0; c < 16; c++) begin
      if (s_ready) begin
        tick();
        got = 1'b1;
        break;
      end
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!got) check("send_timeout", 32'(got), 32'd1);
`ifdef LOADER_CHECKSUM_EN
    ck_acc = ck_acc ^ d;
`endif
  endtask

  task automatic wait_end();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done || err) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) check("end_timeout", 32'(seen), 32'd1);
  endtask

  task automatic do_load(input int nw, input bit odd);
    logic [31:0] w;
    load_id++;
    pulse_start();
    for (int i = 0; i < nw; i++) begin
      w = word_of(i, load_id);
      send_hw(w[31:16], 1'b0);
      send_hw(w[15:0], (i == nw - 1) && !odd);
    end
    if (odd) send_hw(16'h7777, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    else send_hw(ck_corrupt ? (ck_acc ^ 16'h0100) : ck_acc, 1'b0);
`endif
    wait_end();
  endtask

  load_vec_t vecs [6];

  initial begin
    logic [31:0] exp;
    vecs[0] = '{2,  1'b0, 1'b1, 1'b0, 2};
    vecs[1] = '{1,  1'b0, 1'b1, 1'b0, 1};
    vecs[2] = '{0,  1'b1, 1'b0, 1'b1, 0};
    vecs[3] = '{5,  1'b0, 1'b1, 1'b0, 5};
    vecs[4] = '{2,  1'b1, 1'b0, 1'b1, 2};
    vecs[5] = '{16, 1'b0, 1'b1, 1'b0, 16};

    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 16'h0; s_last = 1'b0; fetch_addr = '0;
    tick(); tick();
    // Reset has priority over a start pulse
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst_s_ready",  32'(s_ready),    32'd0);
    check("rst_done",     32'(done),       32'd0);
    check("rst_err",      32'(err),        32'd0);
    check("rst_core_rst", 32'(core_rst),   32'd1);
    check("rst_wcount",   32'(word_count), 32'd0);
    check("rst_fetch",    fetch_data,      HALT);
    reset = 1'b0;
    tick();
    check("idle_s_ready", 32'(s_ready), 32'd0);

    // Two-word reference program
    pulse_start();
    send_hw(16'h0840, 1'b0);
    send_hw(16'h0005, 1'b0);
    send_hw(16'h1000, 1'b0);
    send_hw(16'h0003, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    check("ref_cksum_model", 32'(ck_acc), 32'h1846);
    send_hw(16'h1846, 1'b0);
`endif
    wait_end();
    check("ref_done",     32'(done),       32'd1);
    check("ref_core_rst", 32'(core_rst),   32'd0);
    check("ref_wcount",   32'(word_count), 32'd2);
    fetch_addr = 4'd0; #1 check("ref_fetch0", fetch_data, 32'h0840_0005);
    fetch_addr = 4'd1; #1 check("ref_fetch1", fetch_data, 32'h1000_0003);
    fetch_addr = 4'd2; #1 check("ref_fetch2", fetch_data, HALT);
    tick(); tick();
    check("done_hold", 32'(done), 32'd1);

    // Table of load scenarios
    for (int v = 0; v < 6; v++) begin
      do_load(vecs[v].nwords, vecs[v].odd);
      check($sformatf("vec%0d_done", v),     32'(done),       32'(vecs[v].exp_done));
      check($sformatf("vec%0d_err", v),      32'(err),        32'(vecs[v].exp_err));
      check($sformatf("vec%0d_core_rst", v), 32'(core_rst),   32'(!vecs[v].exp_done));
      check($sformatf("vec%0d_wcount", v),   32'(word_count), 32'(vecs[v].exp_cnt));
      for (int a = 0; a < int'(DEPTH); a++) begin
        fetch_addr = AW'(a);
        #1;
        exp = (vecs[v].exp_done && a < vecs[v].exp_cnt) ? word_of(a, load_id) : HALT;
        check($sformatf("vec%0d_fetch%0d", v, a), fetch_data, exp);
      end
    end

    // Overflow: sixteen words, none marked last
    load_id++;
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      exp = word_of(i, load_id);
      send_hw(exp[31:16], 1'b0);
      send_hw(exp[15:0], 1'b0);
    end
    check("ovf_write_ready", 32'(s_ready),    32'd0);
    check("ovf_write_err",   32'(err),        32'd0);
    check("ovf_write_cnt",   32'(word_count), 32'd15);
    tick();
    check("ovf_err",    32'(err),        32'd1);
    check("ovf_done",   32'(done),       32'd0);
    check("ovf_wcount", 32'(word_count), 32'd16);
    tick(); tick();
    check("err_hold", 32'(err), 32'd1);

    // Backpressure, gaps, ignored start, and s_valid held through WRITE
    pulse_start();
    s_valid = 1'b0; s_data = 16'hDEAD;
    tick(); tick();
    s_valid = 1'b1; s_data = 16'hAAAA; s_last = 1'b0;
    tick();
    s_valid = 1'b0; s_data = 16'hDEAD; start = 1'b1;
    tick();
    start = 1'b0;
    check("bp_lo_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1; s_data = 16'hBBBB;
    tick();
    check("bp_write_ready", 32'(s_ready), 32'd0);
    s_data = 16'hBEEF;
    tick();
    check("bp_hi_ready", 32'(s_ready), 32'd1);
    s_data = 16'hCCCC;
    tick();
    s_data = 16'hDDDD; s_last = 1'b1;
    tick();
    check("bp_write2_ready", 32'(s_ready), 32'd0);
    s_data = 16'hBEEF; s_last = 1'b0;
    tick();
`ifdef LOADER_CHECKSUM_EN
    s_data = 16'hAAAA ^ 16'hBBBB ^ 16'hCCCC ^ 16'hDDDD;
    tick();
`endif
    s_valid = 1'b0;
    check("bp_done",   32'(done),       32'd1);
    check("bp_wcount", 32'(word_count), 32'd2);
    fetch_addr = 4'd0; #1 check("bp_fetch0", fetch_data, 32'hAAAA_BBBB);
    fetch_addr = 4'd1; #1 check("bp_fetch1", fetch_data, 32'hCCCC_DDDD);

    // Reset mid-load, then a fresh single-word load
    load_id++;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      exp = word_of(i, load_id);
      send_hw(exp[31:16], 1'b0);
      send_hw(exp[15:0], 1'b0);
    end
    send_hw(16'h5555, 1'b0);
    reset = 1'b1; start = 1'b1; s_valid = 1'b1; s_data = 16'h6666;
    tick();
    reset = 1'b0; start = 1'b0; s_valid = 1'b0;
    fetch_addr = 4'd0;
    #1;
    check("mrst_s_ready",  32'(s_ready),    32'd0);
    check("mrst_core_rst", 32'(core_rst),   32'd1);
    check("mrst_wcount",   32'(word_count), 32'd0);
    check("mrst_fetch0",   fetch_data,      HALT);
    tick();
    check("mrst_idle_ready", 32'(s_ready), 32'd0);
    do_load(1, 1'b0);
    check("fresh_done",   32'(done),       32'd1);
    check("fresh_wcount", 32'(word_count), 32'd1);
    fetch_addr = 4'd1; #1 check("fresh_fetch1", fetch_data, HALT);
    fetch_addr = 4'd0; #1 check("fresh_fetch0", fetch_data, word_of(0, load_id));

`ifdef LOADER_CHECKSUM_EN
    // Corrupted checksum halfword
    ck_corrupt = 1'b1;
    do_load(3, 1'b0);
    ck_corrupt = 1'b0;
    check("bad_ck_err",  32'(err),  32'd1);
    check("bad_ck_done", 32'(done), 32'd0);
    fetch_addr = 4'd0; #1 check("bad_ck_fetch0", fetch_data, HALT);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DEPTH, default 16, meaning instruction memory depth in 32-bit words.
REQ-002 Parameter AW, default 4, meaning fetch address width, where DEPTH equals 2**AW.
REQ-003 Port clock, input, 1 bit, meaning all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit, meaning synchronous, active-high reset.
REQ-005 Port start, input, 1 bit, meaning a one-cycle pulse that begins a program load.
REQ-006 Port s_valid, input, 1 bit, meaning a halfword is offered on s_data.
REQ-007 Port s_ready, output, 1 bit, meaning the loader accepts a halfword this cycle.
REQ-008 Port s_data, input, 16 bits, meaning an instruction halfword, upper half first.
REQ-009 Port s_last, input, 1 bit, meaning the current halfword is the low half of the final instruction.
REQ-010 Port fetch_addr, input, AW bits, meaning the core's PC.
REQ-011 Port fetch_data, output, 32 bits, meaning the instruction word read at fetch_addr.
REQ-012 Port core_rst, output, 1 bit, meaning hold the processor core in reset.
REQ-013 Port done, output, 1 bit, meaning the program is loaded and valid.
REQ-014 Port err, output, 1 bit, meaning the load failed.
REQ-015 Port word_count, output, AW+1 bits, meaning the number of words written.

Function
REQ-016 The state machine SHALL have the states IDLE, LOAD_HI, LOAD_LO, WRITE, CHK, DONE and ERROR.
REQ-017 A transfer SHALL occur only in a cycle where both s_valid and s_ready are high, and s_valid SHALL be ignored in every other cycle.
REQ-018 s_ready SHALL be high only in LOAD_HI, LOAD_LO and CHK.
REQ-019 In IDLE, DONE and ERROR, a start pulse SHALL clear word_count and move to LOAD_HI on the next cycle.
REQ-020 In LOAD_HI, a transfer SHALL latch s_data into the high half register and move to LOAD_LO.
  - If s_last is also high on that transfer, the loader SHALL move to ERROR instead (odd halfword count).
REQ-021 In LOAD_LO, a transfer SHALL latch s_data into the low half register, capture s_last, and move to WRITE.
REQ-022 WRITE SHALL last exactly one cycle.
  - It SHALL write mem[word_count[AW-1:0]] with {hi, lo}.
  - It SHALL increment word_count.
REQ-023 WRITE exit SHALL be as follows.
  - Captured last set: move to CHK if checksum is enabled, otherwise to DONE.
  - Captured last clear and word_count reaching DEPTH: move to ERROR (overflow).
  - Otherwise: move to LOAD_HI.
REQ-024 fetch_data SHALL be combinational.
  - In DONE, it SHALL equal mem[fetch_addr].
  - In every other state, it SHALL equal 32'hD800_0000, the halt opcode.
  - An fetch_addr at or beyond word_count SHALL also return 32'hD800_0000.
REQ-025 core_rst SHALL be high in every state except DONE.
REQ-026 done SHALL be high only in DONE, and err SHALL be high only in ERROR.
REQ-027 DONE and ERROR SHALL hold until start or reset.
REQ-028 A start pulse in LOAD_HI, LOAD_LO, WRITE or CHK SHALL be ignored.
REQ-029 Minimum load time SHALL be 3 cycles per word when s_valid is held high.

Reset
REQ-030 Reset SHALL take priority over start and over any transfer.
REQ-031 On reset, the outputs SHALL be set as follows: state IDLE, s_ready=0, done=0, err=0, core_rst=1, word_count=0, fetch_data=32'hD800_0000.
REQ-032 Reset during a load SHALL abandon the load.
  - Memory contents are not cleared.
  - Memory contents SHALL be unreachable until the next successful load.

Configuration
REQ-033 Macro LOADER_CHECKSUM_EN SHALL control checksum checking as follows.
  - When defined, the loader SHALL keep a running XOR of all accepted instruction halfwords, cleared on start.
  - When defined, CHK SHALL accept exactly one halfword: a match moves to DONE, a mismatch moves to ERROR.
  - When undefined, the CHK state, the XOR register and the check logic SHALL be absent, and WRITE with last set SHALL go directly to DONE.

Verification
REQ-034 Two-word load: start, then halfwords 0x0840/0x0005 and 0x1000/0x0003 with last on 0x0003, plus checksum 0x1846 if enabled.
  - Required response: done=1, core_rst=0, word_count=2.
  - fetch_addr=1 SHALL give 0x10000003, and fetch_addr=2 SHALL give 0xD8000000.
REQ-035 Odd count: start, then s_last on the first halfword.
  - Required response: err=1, core_rst=1, word_count=0.
REQ-036 Overflow: 16 words with no s_last.
  - Required response: err=1 in the cycle after the 16th WRITE, and word_count=16.
REQ-037 Backpressure and gaps: s_valid toggled 1-0-1 and held during WRITE.
  - Required response: no halfword is lost or duplicated, and s_ready=0 during WRITE.
REQ-038 Reset mid-load after 3 words, then a fresh 1-word load.
  - Required response: word_count=1 and fetch_addr=1 returns 0xD8000000.
REQ-039 With LOADER_CHECKSUM_EN defined, a load whose checksum halfword is deliberately corrupted.
  - Required response: err=1 and done=0.
